// File: rtl/axis_winmul_pkg.sv
// Shared constants and helpers for the windowed multiplier.
// round_sat() is only called when AXIS_WINMUL_ROUND_EN is defined.
package axis_winmul_pkg;

    localparam int PIPE_DEPTH = 3;

    // Round-half-up of a full-width product down to out_w bits, clamped at +max.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] p,
        input int unsigned        full_w,
        input int unsigned        out_w
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_pos;
        int unsigned        shift;
        shift   = full_w - out_w;
        max_pos = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        if (shift == 0) begin
            sum = p;
        end else begin
            sum = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        if (sum > max_pos) begin
            sum = max_pos;
        end
        return sum;
    endfunction

endpackage

// File: rtl/winmul_coef_ram.sv
// Window coefficient RAM: simple dual-port, byte-column writes on port A,
// registered read with enable on port B (read-before-write on collisions).
module winmul_coef_ram
    import axis_winmul_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int COL_NUM    = 2,
    parameter int COL_WIDTH  = 8
) (
    input  logic                           aclk,
    input  logic [COL_NUM-1:0]             we,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [COL_NUM*COL_WIDTH-1:0]   wdata,
    input  logic                           re,
    input  logic [ADDR_WIDTH-1:0]          raddr,
    output logic [COL_NUM*COL_WIDTH-1:0]   rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [COL_NUM*COL_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        for (int c = 0; c < COL_NUM; c++) begin
            if (we[c]) begin
                mem[waddr][c*COL_WIDTH +: COL_WIDTH] <= wdata[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_window_multiplier_mc.sv
// Multi-channel AXI-Stream window multiplier: each sample is scaled by a
// per-index RAM coefficient. Define AXIS_WINMUL_ROUND_EN for round-half-up output.
module axis_window_multiplier_mc
    import axis_winmul_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int SIGNAL_WIDTH  = 14,
    parameter int WINDOW_WIDTH  = 14,
    parameter int PRODUCT_WIDTH = 14,
    parameter int ADDR_WIDTH    = 12,
    parameter int COL_NUM       = 2,
    parameter int COL_WIDTH     = 8
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_CH*SIGNAL_WIDTH-1:0]    s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [NUM_CH*PRODUCT_WIDTH-1:0]   m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic [ADDR_WIDTH-1:0]             bram_porta_addr,
    input  logic [COL_NUM*COL_WIDTH-1:0]      bram_porta_wrdata,
    input  logic [COL_NUM-1:0]                bram_porta_we,
    input  logic [ADDR_WIDTH-1:0]             cfg_len_m1,
    output logic                              frame_err
);

    localparam int FULL_WIDTH = SIGNAL_WIDTH + WINDOW_WIDTH;

    logic [ADDR_WIDTH-1:0]                 idx;
    logic [ADDR_WIDTH-1:0]                 len_m1;
    logic [ADDR_WIDTH-1:0]                 cur_len;
    logic                                  hs;
    logic                                  at_last;
    logic                                  pipe_en;
    logic [PIPE_DEPTH-1:0]                 vld;
    logic [PIPE_DEPTH-1:0]                 lst;
    logic [NUM_CH*SIGNAL_WIDTH-1:0]        s0_data;
    logic [COL_NUM*COL_WIDTH-1:0]          ram_rdata;
    logic [WINDOW_WIDTH-1:0]               coef;
    logic [FULL_WIDTH-1:0]                 smp_ext;
    logic [FULL_WIDTH-1:0]                 coef_ext;
    logic [NUM_CH-1:0][FULL_WIDTH-1:0]     prod_next;
    logic [NUM_CH-1:0][FULL_WIDTH-1:0]     s1_prod;
    logic [NUM_CH*PRODUCT_WIDTH-1:0]       out_next;
    logic                                  unused_bits;

    // A single enable freezes every stage, including the RAM read, so a stall never loses a coefficient.
    assign pipe_en       = ~vld[PIPE_DEPTH-1] | m_axis_tready;
    assign s_axis_tready = pipe_en;
    assign hs            = s_axis_tvalid & pipe_en;
    assign cur_len       = (idx == '0) ? cfg_len_m1 : len_m1;
    assign at_last       = (idx == cur_len);
    assign coef          = ram_rdata[WINDOW_WIDTH-1:0];
    assign m_axis_tvalid = vld[PIPE_DEPTH-1];
    assign m_axis_tlast  = lst[PIPE_DEPTH-1];
    assign unused_bits   = ^{ram_rdata, s1_prod};

    winmul_coef_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COL_NUM    (COL_NUM),
        .COL_WIDTH  (COL_WIDTH)
    ) u_coef_ram (
        .aclk  (aclk),
        .we    (bram_porta_we),
        .waddr (bram_porta_addr),
        .wdata (bram_porta_wrdata),
        .re    (pipe_en),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    // Frame tracking resyncs on either the counted end or an upstream tlast.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx       <= '0;
            len_m1    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= hs & (s_axis_tlast ^ at_last);
            if (hs) begin
                if (idx == '0) begin
                    len_m1 <= cfg_len_m1;
                end
                idx <= (at_last | s_axis_tlast) ? '0 : idx + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld          <= '0;
            lst          <= '0;
            s0_data      <= '0;
            s1_prod      <= '0;
            m_axis_tdata <= '0;
        end else if (pipe_en) begin
            vld          <= {vld[PIPE_DEPTH-2:0], hs};
            lst          <= {lst[PIPE_DEPTH-2:0], hs & at_last};
            s0_data      <= s_axis_tdata;
            s1_prod      <= prod_next;
            m_axis_tdata <= out_next;
        end
    end

    // The product never exceeds FULL_WIDTH bits because the coefficient is non-negative.
    always_comb begin
        prod_next = '0;
        smp_ext   = '0;
        coef_ext  = {{SIGNAL_WIDTH{1'b0}}, coef};
        for (int k = 0; k < NUM_CH; k++) begin
            smp_ext = {{WINDOW_WIDTH{s0_data[k*SIGNAL_WIDTH + SIGNAL_WIDTH - 1]}},
                       s0_data[k*SIGNAL_WIDTH +: SIGNAL_WIDTH]};
            prod_next[k] = smp_ext * coef_ext;
        end
    end

`ifdef AXIS_WINMUL_ROUND_EN
    always_comb begin
        out_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_next[k*PRODUCT_WIDTH +: PRODUCT_WIDTH] = PRODUCT_WIDTH'(
                round_sat(64'($signed(s1_prod[k])), FULL_WIDTH, PRODUCT_WIDTH));
        end
    end
`else
    always_comb begin
        out_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_next[k*PRODUCT_WIDTH +: PRODUCT_WIDTH] = s1_prod[k][FULL_WIDTH-1 -: PRODUCT_WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_axis_window_multiplier_mc.sv
// Self-checking bench for axis_window_multiplier_mc: vector table, frame and
// reset sequences, and a randomly back-pressured stream against a scoreboard.
module tb_axis_window_multiplier_mc;

    localparam int NUM_CH = 2;
    localparam int SW     = 14;
    localparam int WW     = 14;
    localparam int PW     = 14;
    localparam int AW     = 12;
    localparam int COLN   = 2;
    localparam int COLW   = 8;
    localparam int FW     = SW + WW;
    localparam int SHIFT  = FW - PW;

    typedef struct {
        int coef;
        int smp0;
        int smp1;
        int exp0;
        int exp1;
    } vec_t;

    typedef struct {
        logic [NUM_CH*PW-1:0] data;
        logic                 last;
    } exp_t;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic [NUM_CH*SW-1:0]     s_axis_tdata = '0;
    logic                     s_axis_tvalid = 1'b0;
    logic                     s_axis_tlast = 1'b0;
    logic                     s_axis_tready;
    logic [NUM_CH*PW-1:0]     m_axis_tdata;
    logic                     m_axis_tvalid;
    logic                     m_axis_tlast;
    logic                     m_axis_tready = 1'b1;
    logic [AW-1:0]            bram_porta_addr = '0;
    logic [COLN*COLW-1:0]     bram_porta_wrdata = '0;
    logic [COLN-1:0]          bram_porta_we = '0;
    logic [AW-1:0]            cfg_len_m1 = '0;
    logic                     frame_err;

    int                       checks = 0;
    int                       errors = 0;
    int                       in_count = 0;
    int                       out_count = 0;
    int                       err_pulses = 0;
    int                       last_count = 0;
    int                       tb_coef [1<<AW];
    int                       m_idx = 0;
    int                       m_len = 0;
    logic                     err_pending = 1'b0;
    logic                     stall_prev = 1'b0;
    logic [NUM_CH*PW-1:0]     stall_data = '0;
    logic signed [PW-1:0]     last_out0 = '0;
    logic signed [PW-1:0]     last_out1 = '0;
    logic                     rand_ready = 1'b0;
    exp_t                     sb [$];
    vec_t                     vecs [6];

    axis_window_multiplier_mc #(
        .NUM_CH        (NUM_CH),
        .SIGNAL_WIDTH  (SW),
        .WINDOW_WIDTH  (WW),
        .PRODUCT_WIDTH (PW),
        .ADDR_WIDTH    (AW),
        .COL_NUM       (COLN),
        .COL_WIDTH     (COLW)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .bram_porta_addr   (bram_porta_addr),
        .bram_porta_wrdata (bram_porta_wrdata),
        .bram_porta_we     (bram_porta_we),
        .cfg_len_m1        (cfg_len_m1),
        .frame_err         (frame_err)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: signed sample times unsigned coefficient, floor or round-half-up.
    function automatic longint expectCh(input longint smp, input longint c);
        longint p;
        longint r;
        p = smp * c;
`ifdef AXIS_WINMUL_ROUND_EN
        r = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > (longint'(1) <<< (PW - 1)) - 1) r = (longint'(1) <<< (PW - 1)) - 1;
`else
        r = p >>> SHIFT;
`endif
        return r;
    endfunction

    task automatic monitorStep();
        exp_t   e;
        logic   is_last;
        longint smp;
        if (!aresetn) begin
            sb.delete();
            m_idx       = 0;
            m_len       = 0;
            err_pending = 1'b0;
            stall_prev  = 1'b0;
            in_count    = out_count;
            return;
        end
        checkOutput("frame_err", longint'(frame_err), longint'(err_pending));
        if (frame_err) err_pulses++;
        err_pending = 1'b0;
        if (stall_prev) begin
            checkOutput("hold_valid", longint'(m_axis_tvalid), 1);
            checkOutput("hold_data", longint'(m_axis_tdata), longint'(stall_data));
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got data %0h expected none", m_axis_tdata);
            end else begin
                e = sb.pop_front();
                checkOutput("data_ch0", longint'($signed(m_axis_tdata[PW-1:0])), longint'($signed(e.data[PW-1:0])));
                checkOutput("data_ch1", longint'($signed(m_axis_tdata[2*PW-1:PW])), longint'($signed(e.data[2*PW-1:PW])));
                checkOutput("tlast", longint'(m_axis_tlast), longint'(e.last));
            end
            last_out0 = $signed(m_axis_tdata[PW-1:0]);
            last_out1 = $signed(m_axis_tdata[2*PW-1:PW]);
            out_count++;
            if (m_axis_tlast) last_count++;
        end
        if (s_axis_tvalid && s_axis_tready) begin
            in_count++;
            if (m_idx == 0) m_len = int'(cfg_len_m1);
            is_last = (m_idx == m_len);
            for (int k = 0; k < NUM_CH; k++) begin
                smp = longint'($signed(s_axis_tdata[k*SW +: SW]));
                e.data[k*PW +: PW] = PW'(expectCh(smp, longint'(tb_coef[m_idx] & ((1 << WW) - 1))));
            end
            e.last = is_last;
            sb.push_back(e);
            err_pending = (s_axis_tlast != is_last);
            m_idx = (is_last || s_axis_tlast) ? 0 : m_idx + 1;
        end
    endtask

    task automatic writeCoefCols(input int addr, input logic [COLN*COLW-1:0] val, input logic [COLN-1:0] we);
        logic [31:0] tmp;
        bram_porta_addr   = AW'(addr);
        bram_porta_wrdata = val;
        bram_porta_we     = we;
        @(posedge aclk);
        #1;
        bram_porta_we = '0;
        tmp = 32'(tb_coef[addr]);
        for (int c = 0; c < COLN; c++) begin
            if (we[c]) tmp[c*COLW +: COLW] = val[c*COLW +: COLW];
        end
        tb_coef[addr] = int'(tmp);
    endtask

    task automatic writeCoef(input int addr, input int val);
        writeCoefCols(addr, (COLN*COLW)'(val), '1);
    endtask

    // Drives one beat and returns just after the edge that accepted it.
    task automatic applyStimulus(input int smp0, input int smp1, input logic last);
        logic ok;
        s_axis_tdata  = {SW'(smp1), SW'(smp0)};
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL input_timeout: got tready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic waitOutputs(input int target);
        for (int c = 0; c < 400 && out_count < target; c++) @(negedge aclk);
        #1;
        checkOutput("output_count", out_count, target);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int base;
        int e0;
        int l0;
        int cyc;

        fork
            forever begin
                @(negedge aclk);
                monitorStep();
            end
            forever begin
                @(posedge aclk);
                #1;
                if (rand_ready) m_axis_tready = 1'($urandom_range(1));
            end
        join_none

        vecs[0] = '{8192, 1000, -1000, 500, -500};
        vecs[2] = '{0, 5000, -5000, 0, 0};
`ifdef AXIS_WINMUL_ROUND_EN
        vecs[1] = '{16383, -8192, 8191, -8191, 8191};
        vecs[3] = '{1, -1, 1, 0, 0};
        vecs[4] = '{12345, 3000, -3000, 2260, -2260};
        vecs[5] = '{4096, 6, -6, 2, -1};
`else
        vecs[1] = '{16383, -8192, 8191, -8192, 8190};
        vecs[3] = '{1, -1, 1, -1, 0};
        vecs[4] = '{12345, 3000, -3000, 2260, -2261};
        vecs[5] = '{4096, 6, -6, 1, -2};
`endif

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset_tvalid", longint'(m_axis_tvalid), 0);
        checkOutput("reset_tlast", longint'(m_axis_tlast), 0);
        checkOutput("reset_tdata", longint'(m_axis_tdata), 0);
        checkOutput("reset_frame_err", longint'(frame_err), 0);
        checkOutput("reset_tready", longint'(s_axis_tready), 1);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        $display("[TB] vector table");
        cfg_len_m1 = '0;
        for (int i = 0; i < 6; i++) begin
            writeCoef(0, vecs[i].coef);
            base = out_count;
            applyStimulus(vecs[i].smp0, vecs[i].smp1, 1'b1);
            cyc = 1;
            while (!m_axis_tvalid && cyc < 20) begin
                @(posedge aclk);
                #1;
                cyc++;
            end
            checkOutput("latency", cyc, 3);
            waitOutputs(base + 1);
            checkOutput("vec_ch0", longint'(last_out0), vecs[i].exp0);
            checkOutput("vec_ch1", longint'(last_out1), vecs[i].exp1);
        end

        $display("[TB] two aligned frames of four");
        cfg_len_m1 = AW'(3);
        writeCoef(0, 8192);
        writeCoef(1, 4096);
        writeCoef(2, 2048);
        writeCoefCols(3, 16'h3fff, 2'b11);
        writeCoefCols(3, 16'h0012, 2'b01);
        e0 = err_pulses;
        l0 = last_count;
        base = out_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(100 * (i + 1), -50 * (i + 1), (i == 3) || (i == 7));
        end
        waitOutputs(base + 8);
        checkOutput("aligned_err_pulses", err_pulses - e0, 0);
        checkOutput("aligned_last_count", last_count - l0, 2);

        $display("[TB] early tlast resync");
        e0 = err_pulses;
        base = out_count;
        applyStimulus(1000, -1000, 1'b0);
        applyStimulus(1000, -1000, 1'b1);
        applyStimulus(1000, -1000, 1'b0);
        waitOutputs(base + 3);
        checkOutput("early_err_pulses", err_pulses - e0, 1);
        checkOutput("early_third_ch0", longint'(last_out0), 500);
        checkOutput("early_third_ch1", longint'(last_out1), -500);

        $display("[TB] reset mid-frame");
        applyStimulus(2000, 300, 1'b0);
        applyStimulus(2000, 300, 1'b0);
        applyStimulus(2000, 300, 1'b0);
        checkOutput("pre_reset_tvalid", longint'(m_axis_tvalid), 1);
        aresetn = 1'b0;
        #1;
        checkOutput("async_reset_tvalid", longint'(m_axis_tvalid), 0);
        checkOutput("async_reset_tready", longint'(s_axis_tready), 1);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        base = out_count;
        applyStimulus(1000, -1000, 1'b0);
        waitOutputs(base + 1);
        checkOutput("post_reset_ch0", longint'(last_out0), 500);
        checkOutput("post_reset_ch1", longint'(last_out1), -500);

        $display("[TB] random back-pressure stream");
        for (int a = 0; a < 16; a++) writeCoef(a, int'($urandom_range(16383)));
        cfg_len_m1 = AW'(7);
        rand_ready = 1'b1;
        for (int n = 0; n < 4096; n++) begin
            if ($urandom_range(15) == 0) cfg_len_m1 = AW'($urandom_range(15));
            if ($urandom_range(3) == 0) begin
                @(posedge aclk);
                #1;
            end
            applyStimulus(int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
                          $urandom_range(7) == 0);
        end
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 100 && out_count < in_count; c++) @(negedge aclk);
        #1;
        checkOutput("drain_count", out_count, in_count);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
